// File: rtl/risc16_loader.sv
// Boot loader for the risc16 core: takes a length-prefixed big-endian word stream,
// writes it to memory from BASE_ADDR, then releases the core and passes its bus through.
module risc16_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned MEM_WORDS = 32768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        cpu_rst,
    output logic        done,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    input  logic        cpu_oe,
    input  logic        cpu_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_dout,
    output logic        mem_oe,
    output logic        mem_we
);

    typedef enum logic [2:0] {LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, RUN} state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] waddr_q, waddr_d;
    logic [15:0] word_q, word_d;
    logic        accept;
    logic        in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LEN_HI;
            len_q   <= 16'h0000;
            cnt_q   <= 16'h0000;
            waddr_q <= BASE_ADDR;
            word_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            word_q  <= word_d;
        end
    end

    assign rx_ready = !rst && (state_q == LEN_HI || state_q == LEN_LO ||
                               state_q == DAT_HI || state_q == DAT_LO);
    assign accept   = rx_valid && rx_ready;
    // Words past the memory size still advance cnt/waddr so the stream stays aligned.
    assign in_range = {16'h0000, cnt_q} < MEM_WORDS;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        word_d  = word_q;
        case (state_q)
            LEN_HI: if (accept) begin
                len_d[15:8] = rx_data;
                state_d     = LEN_LO;
            end
            LEN_LO: if (accept) begin
                len_d[7:0] = rx_data;
                state_d    = ({len_q[15:8], rx_data} == 16'h0000) ? RUN : DAT_HI;
            end
            DAT_HI: if (accept) begin
                word_d[15:8] = rx_data;
                state_d      = DAT_LO;
            end
            DAT_LO: if (accept) begin
                word_d[7:0] = rx_data;
                state_d     = WRITE;
            end
            WRITE: begin
                cnt_d   = cnt_q + 16'd1;
                waddr_d = waddr_q + 16'd2;
                state_d = (cnt_q + 16'd1 == len_q) ? RUN : DAT_HI;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        mem_addr = waddr_q;
        mem_dout = word_q;
        mem_oe   = 1'b0;
        mem_we   = 1'b0;
        if (!rst) begin
            if (state_q == WRITE) begin
                mem_we = in_range;
            end else if (state_q == RUN) begin
                mem_addr = cpu_addr;
                mem_dout = cpu_dout;
                mem_oe   = cpu_oe;
                mem_we   = cpu_we;
            end
        end
    end

    assign cpu_rst = rst || (state_q != RUN);
    assign done    = !rst && (state_q == RUN);

endmodule

// File: tb/tb_risc16_loader.sv
// Self-checking bench for risc16_loader: two instances (full memory and a 2-word memory)
// share one byte stream; writes are checked against a list derived from the stream itself.
module tb_risc16_loader;

    localparam logic [15:0] BASE_A = 16'h0000;
    localparam logic [15:0] BASE_B = 16'h0100;
    localparam int          MW_B   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] cpu_addr, cpu_dout;
    logic        cpu_oe, cpu_we;

    logic        rx_ready_a, cpu_rst_a, done_a, mem_oe_a, mem_we_a;
    logic [15:0] mem_addr_a, mem_dout_a;
    logic        rx_ready_b, cpu_rst_b, done_b, mem_oe_b, mem_we_b;
    logic [15:0] mem_addr_b, mem_dout_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    risc16_loader #(.BASE_ADDR(BASE_A), .MEM_WORDS(32768)) dut_a (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready_a),
        .cpu_rst(cpu_rst_a), .done(done_a), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_oe(cpu_oe), .cpu_we(cpu_we), .mem_addr(mem_addr_a), .mem_dout(mem_dout_a),
        .mem_oe(mem_oe_a), .mem_we(mem_we_a));

    risc16_loader #(.BASE_ADDR(BASE_B), .MEM_WORDS(MW_B)) dut_b (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready_b),
        .cpu_rst(cpu_rst_b), .done(done_b), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_oe(cpu_oe), .cpu_we(cpu_we), .mem_addr(mem_addr_b), .mem_dout(mem_dout_b),
        .mem_oe(mem_oe_b), .mem_we(mem_we_b));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rand_cpu();
        cpu_addr = 16'($urandom);
        cpu_dout = 16'($urandom);
        cpu_oe   = 1'($urandom);
        cpu_we   = 1'($urandom);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        rand_cpu();
        repeat (2) begin
            @(negedge clk);
            chk("rst_outs_a", {rx_ready_a, cpu_rst_a, done_a, mem_we_a, mem_oe_a}, 5'b01000);
            chk("rst_outs_b", {rx_ready_b, cpu_rst_b, done_b, mem_we_b, mem_oe_b}, 5'b01000);
        end
        rst      = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_a", {rx_ready_a, cpu_rst_a, done_a, mem_we_a, mem_oe_a, mem_addr_a},
            {5'b11000, BASE_A});
        chk("post_rst_b", {mem_addr_b, done_b}, {BASE_B, 1'b0});
    endtask

    // Drives q with random or solid rx_valid; returns early after stop_w writes if stop_w > 0.
    task automatic run_load(input logic [7:0] q[$], input bit rnd, input int stop_w);
        int          idx = 0, wa = 0, wb = 0;
        bit          pend = 1'b0, last_w = 1'b0, finished = 1'b0;
        logic [15:0] len, w;
        len = {q[0], q[1]};
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (pend) idx++;
            if (last_w) begin
                chk("done_after_last", {done_a, cpu_rst_a}, 2'b10);
                last_w = 1'b0;
            end
            chk("cpu_rst_vs_done", cpu_rst_a, !done_a);
            if (!rx_ready_a && !done_a) begin
                if (wa >= int'(len)) chk("extra_write_a", 64'(wa), 64'(len));
                else begin
                    w = {q[2 + 2*wa], q[3 + 2*wa]};
                    chk("wr_a", {mem_we_a, mem_oe_a, mem_addr_a, mem_dout_a},
                        {1'b1, 1'b0, 16'(BASE_A + 16'(2*wa)), w});
                end
                wa++;
                if (wa == int'(len)) last_w = 1'b1;
            end else if (!done_a) begin
                chk("idle_bus_a", {mem_we_a, mem_oe_a}, 2'b00);
            end
            if (!rx_ready_b && !done_b) begin
                if (wb < int'(len)) begin
                    w = {q[2 + 2*wb], q[3 + 2*wb]};
                    chk("wr_b", {mem_we_b, mem_oe_b, mem_addr_b, mem_dout_b},
                        {wb < MW_B, 1'b0, 16'(BASE_B + 16'(2*wb)), w});
                end
                wb++;
            end else if (!done_b) begin
                chk("idle_bus_b", {mem_we_b, mem_oe_b}, 2'b00);
            end
            if (stop_w > 0 && wa == stop_w) return;
            if (done_a && done_b && idx == q.size()) finished = 1'b1;
            rx_valid = (idx < q.size()) && (!rnd || $urandom_range(0, 2) != 0);
            rx_data  = (idx < q.size()) ? q[idx] : 8'($urandom);
            rand_cpu();
            #1 pend = rx_valid && rx_ready_a;
        end
        rx_valid = 1'b0;
        chk("load_done", {finished, done_a, done_b}, 3'b111);
        chk("nwrites_a", 64'(wa), 64'(len));
        chk("nwrites_b", 64'(wb), 64'(len));
    endtask

    task automatic post_run(input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            rand_cpu();
            #1;
            chk("run_pass_a", {rx_ready_a, done_a, cpu_rst_a, mem_addr_a, mem_dout_a, mem_oe_a, mem_we_a},
                {3'b010, cpu_addr, cpu_dout, cpu_oe, cpu_we});
            chk("run_pass_b", {rx_ready_b, done_b, mem_addr_b, mem_we_b},
                {2'b01, cpu_addr, cpu_we});
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        int         n;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        cpu_addr = 16'h0; cpu_dout = 16'h0; cpu_oe = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        do_reset();

        // 3-word load, rx_valid solid; then a core read passes straight through
        q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h0F};
        run_load(q, 1'b0, 0);
        cpu_addr = 16'h0002; cpu_oe = 1'b1; cpu_we = 1'b0; #1;
        chk("core_read", {mem_addr_a, mem_oe_a, mem_we_a}, {16'h0002, 2'b10});
        post_run(6);

        // zero length
        do_reset();
        q = '{8'h00, 8'h00};
        run_load(q, 1'b0, 0);

        // same 3-word stream with random gaps
        do_reset();
        q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h0F};
        run_load(q, 1'b1, 0);

        // overflow case exercised on the 2-word instance
        do_reset();
        q = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
        run_load(q, 1'b1, 0);

        // reset after first data word, then a fresh 1-word load
        do_reset();
        q = '{8'h00, 8'h02, 8'hAA, 8'hAA, 8'h55, 8'h55};
        run_load(q, 1'b0, 1);
        do_reset();
        q = '{8'h00, 8'h01, 8'hBE, 8'hEF};
        run_load(q, 1'b1, 0);
        post_run(4);

        // random-length random-content loads
        for (int t = 0; t < 3; t++) begin
            do_reset();
            n = $urandom_range(1, 12);
            q = '{8'h00, 8'(n)};
            for (int i = 0; i < 2*n; i++) q.push_back(8'($urandom));
            run_load(q, 1'b1, 0);
            post_run(3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
